// File: rtl/name_table_pkg.sv
// Shared name-table constants, FSM encoding and beat helpers for the name CAM and streamer.
// Defining NAME_STREAM_NUL_EN appends a single 8'h00 terminator beat to every streamed name.
package name_table_pkg;

    localparam int CHAR_W  = 8;
    localparam int MAX_LEN = 8;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = MAX_LEN * CHAR_W;
    localparam int LEN_W   = 4;
    localparam int ENTRY_W = LEN_W + DATA_W;
    localparam int CNT_W   = LEN_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    // Character k sits in byte k of the data field, so the first letter is the low byte.
    localparam logic [ENTRY_W-1:0] ENTRY_LEO    = {4'd3, 64'h0000_0000_004F_454C};
    localparam logic [ENTRY_W-1:0] ENTRY_AARON  = {4'd5, 64'h0000_004E_4F52_4141};
    localparam logic [ENTRY_W-1:0] ENTRY_HOLLY  = {4'd5, 64'h0000_0059_4C4C_4F48};
    localparam logic [ENTRY_W-1:0] ENTRY_DAVID  = {4'd5, 64'h0000_0044_4956_4144};
    localparam logic [ENTRY_W-1:0] ENTRY_CLAIRE = {4'd6, 64'h0000_4552_4941_4C43};
    localparam logic [ENTRY_W-1:0] ENTRY_FRANK  = {4'd5, 64'h0000_004B_4E41_5246};
    localparam logic [ENTRY_W-1:0] ENTRY_LANCE  = {4'd5, 64'h0000_0045_434E_414C};
    localparam logic [ENTRY_W-1:0] ENTRY_RYAN   = {4'd4, 64'h0000_0000_4E41_5952};

    function automatic logic [CNT_W-1:0] beat_count(input logic [LEN_W-1:0] len);
`ifdef NAME_STREAM_NUL_EN
        return {1'b0, len} + CNT_W'(1);
`else
        return {1'b0, len};
`endif
    endfunction

    // Beats at or past the name length read as NUL, which also covers the terminator beat.
    function automatic logic [CHAR_W-1:0] char_at(input logic [DATA_W-1:0] data,
                                                  input logic [LEN_W-1:0]  len,
                                                  input logic [CNT_W-1:0]  k);
        logic [CHAR_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((CNT_W'(i) == k) && (k < {1'b0, len})) begin
                c = data[i*CHAR_W +: CHAR_W];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/name_table.sv
// Combinational name ROM: entry address to {len, data}, shared contents with the name CAM.
module name_table
    import name_table_pkg::*;
(
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [ENTRY_W-1:0] entry_o
);

    always_comb begin
        entry_o = '0;
        case (addr_i)
            3'd0:    entry_o = ENTRY_LEO;
            3'd1:    entry_o = ENTRY_AARON;
            3'd2:    entry_o = ENTRY_HOLLY;
            3'd3:    entry_o = ENTRY_DAVID;
            3'd4:    entry_o = ENTRY_CLAIRE;
            3'd5:    entry_o = ENTRY_FRANK;
            3'd6:    entry_o = ENTRY_LANCE;
            3'd7:    entry_o = ENTRY_RYAN;
            default: entry_o = '0;
        endcase
    end

endmodule

// File: rtl/name_streamer.sv
// Streams the name stored at a table address one character per beat over a valid/ready port.
// Build with NAME_STREAM_NUL_EN defined to end every name with a NUL beat carrying out_last.
module name_streamer
    import name_table_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_last,
    output logic              busy
);

    logic [ENTRY_W-1:0] romEntry;
    logic [LEN_W-1:0]   romLen;
    logic [DATA_W-1:0]  romData;

    state_t             state_q;
    logic [DATA_W-1:0]  word_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   idx_q;
    logic [CNT_W-1:0]   idx_d;
    logic               out_valid_q;
    logic [CHAR_W-1:0]  out_char_q;
    logic               out_last_q;
    logic               busy_q;

    name_table u_table (
        .addr_i  (req_addr),
        .entry_o (romEntry)
    );

    assign romLen  = romEntry[ENTRY_W-1 -: LEN_W];
    assign romData = romEntry[DATA_W-1:0];
    assign idx_d   = idx_q + CNT_W'(1);

    // A zero-beat entry is accepted but never leaves IDLE, so nothing is emitted for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && (beat_count(romLen) != '0)) begin
                        state_q     <= ST_SEND;
                        word_q      <= romData;
                        len_q       <= romLen;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_char_q  <= char_at(romData, romLen, '0);
                        out_last_q  <= (beat_count(romLen) == CNT_W'(1));
                        busy_q      <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= ST_IDLE;
                            idx_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_char_q  <= '0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            idx_q      <= idx_d;
                            out_char_q <= char_at(word_q, len_q, idx_d);
                            out_last_q <= (idx_d == beat_count(len_q) - CNT_W'(1));
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_name_streamer.sv
// Self-checking bench for name_streamer: directed scenarios plus random traffic against a string-based model.
module tb_name_streamer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_addr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_last;
    logic       busy;

    typedef struct {
        logic [7:0] ch;
        logic       last;
    } beat_t;

    beat_t expQ[$];
    string names[8];
    int    checkCount = 0;
    int    passCount  = 0;

    name_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // The model queue holds every beat still owed to the consumer, in order.
    task automatic pushName(input int a);
        int    n;
        beat_t b;
        n = names[a].len();
        for (int k = 0; k < n; k++) begin
            b.ch = names[a][k];
`ifdef NAME_STREAM_NUL_EN
            b.last = 1'b0;
`else
            b.last = (k == n - 1);
`endif
            expQ.push_back(b);
        end
`ifdef NAME_STREAM_NUL_EN
        b.ch   = 8'h00;
        b.last = 1'b1;
        expQ.push_back(b);
`endif
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, expQ.size() == 0});
        checkOutput({tag, ".busy"},      {31'd0, busy},      {31'd0, expQ.size() != 0});
        checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, expQ.size() != 0});
        if (expQ.size() != 0) begin
            checkOutput({tag, ".out_char"}, {24'd0, out_char}, {24'd0, expQ[0].ch});
            checkOutput({tag, ".out_last"}, {31'd0, out_last}, {31'd0, expQ[0].last});
        end
    endtask

    // One clock of traffic: drive inputs, predict the handshakes, advance, then compare.
    task automatic applyStimulus(input logic rv, input logic [2:0] ra, input logic ordy, input string tag);
        logic  hs;
        logic  bt;
        beat_t tmp;
        req_valid = rv;
        req_addr  = ra;
        out_ready = ordy;
        hs = rv && (expQ.size() == 0);
        bt = (expQ.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (bt) tmp = expQ.pop_front();
        if (hs) pushName(int'(ra));
        checkState(tag);
    endtask

    initial begin
        int a;
        int guard;
        logic willAccept;

        names[0] = "LEO";    names[1] = "AARON"; names[2] = "HOLLY"; names[3] = "DAVID";
        names[4] = "CLAIRE"; names[5] = "FRANK"; names[6] = "LANCE"; names[7] = "RYAN";

        reset     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 3'd3;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkState("reset");
        checkOutput("reset.char", {24'd0, out_char}, 32'd0);
        checkOutput("reset.last", {31'd0, out_last}, 32'd0);
        req_valid = 1'b0;
        reset     = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b1, "idle");

        applyStimulus(1'b1, 3'd0, 1'b1, "t1");
        repeat (4) applyStimulus(1'b0, 3'd0, 1'b1, "t1");

        applyStimulus(1'b1, 3'd4, 1'b1, "t2");
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 3'd4, (i % 2) == 0, "t2");

        applyStimulus(1'b1, 3'd7, 1'b1, "t3");
        repeat (5) applyStimulus(1'b1, 3'd1, 1'b1, "t3");
        repeat (7) applyStimulus(1'b0, 3'd0, 1'b1, "t3");

        applyStimulus(1'b1, 3'd2, 1'b1, "t4");
        repeat (2) applyStimulus(1'b0, 3'd0, 1'b1, "t4");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t4.async_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t4.async_busy",  {31'd0, busy},      32'd0);
        checkOutput("t4.async_ready", {31'd0, req_ready}, 32'd1);
        expQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 3'd5, 1'b1, "t4b");
        repeat (6) applyStimulus(1'b0, 3'd0, 1'b1, "t4b");

        a     = 0;
        guard = 0;
        while (a < 8 && guard < 200) begin
            willAccept = (expQ.size() == 0);
            applyStimulus(1'b1, a[2:0], 1'b1, "t5");
            if (willAccept) a++;
            guard++;
        end
        repeat (12) applyStimulus(1'b0, 3'd0, 1'b1, "t5");

        repeat (400) begin
            applyStimulus($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, "rnd");
        end
        repeat (12) applyStimulus(1'b0, 3'd0, 1'b1, "drain");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
